// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer for branches resolved in EX.
// One-shot PC select, held IF/ID flush and saturating taken/not-taken counts.
module branch_redirect_ctrl #(
    parameter int ADDR_W       = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic [4:0]        ex_opcode,
    input  logic [1:0]        ex_flags,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              stat_clr,
    output logic              pc_branch_sel,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush_ifid,
    output logic              busy,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  not_taken_cnt
);

    localparam logic [4:0] OP_BEQ = 5'b10011;
    localparam logic [4:0] OP_BLT = 5'b10100;
    localparam logic [4:0] OP_BGT = 5'b10101;
    localparam logic [4:0] OP_BNE = 5'b10110;

    localparam logic [3:0] FLUSH_INIT = FLUSH_CYCLES[3:0];
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t            state, state_d;
    logic [3:0]        flush_cnt, flush_cnt_d;
    logic              sel_d, flush_d, busy_d;
    logic [ADDR_W-1:0] target_d;

    logic flag_z, flag_n;
    logic is_br, cond;
    logic strobe, br_taken, br_not_taken;

    assign flag_z = ex_flags[1];
    assign flag_n = ex_flags[0];

    always_comb begin
        is_br = 1'b0;
        cond  = 1'b0;
        unique case (1'b1)
            (ex_opcode == OP_BEQ): begin
                is_br = 1'b1;
                cond  = flag_z;
            end
            (ex_opcode == OP_BNE): begin
                is_br = 1'b1;
                cond  = ~flag_z;
            end
            (ex_opcode == OP_BLT): begin
                is_br = 1'b1;
                cond  = flag_n;
            end
            (ex_opcode == OP_BGT): begin
                is_br = 1'b1;
                cond  = ~flag_n & ~flag_z;
            end
            default: ;
        endcase
    end

    // Wrong-path branches arriving during FLUSH never reach the strobe.
    assign strobe       = (state == IDLE) & ex_valid & ~stall & is_br;
    assign br_taken     = strobe & cond;
    assign br_not_taken = strobe & ~cond;

    always_comb begin
        state_d     = state;
        flush_cnt_d = flush_cnt;
        sel_d       = pc_branch_sel;
        target_d    = pc_target;
        flush_d     = flush_ifid;
        busy_d      = busy;
        unique case (state)
            IDLE: begin
                if (br_taken) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                    sel_d       = 1'b1;
                    target_d    = ex_target;
                    flush_d     = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    sel_d       = 1'b0;
                    flush_cnt_d = flush_cnt - 4'd1;
                    if (flush_cnt == 4'd1) begin
                        state_d = IDLE;
                        flush_d = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            flush_cnt     <= '0;
            pc_branch_sel <= 1'b0;
            pc_target     <= '0;
            flush_ifid    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            flush_cnt     <= flush_cnt_d;
            pc_branch_sel <= sel_d;
            pc_target     <= target_d;
            flush_ifid    <= flush_d;
            busy          <= busy_d;
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else if (stat_clr) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else begin
            if (br_taken && taken_cnt != CNT_MAX)
                taken_cnt <= taken_cnt + CNT_W'(1);
            if (br_not_taken && not_taken_cnt != CNT_MAX)
                not_taken_cnt <= not_taken_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl.
// A second CNT_W=4 instance shares stimulus for the saturation case.
module tb_branch_redirect_ctrl;

    localparam logic [4:0] BEQ = 5'b10011;
    localparam logic [4:0] BLT = 5'b10100;
    localparam logic [4:0] BGT = 5'b10101;
    localparam logic [4:0] BNE = 5'b10110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        ex_valid;
    logic [4:0]  ex_opcode;
    logic [1:0]  ex_flags;
    logic [15:0] ex_target;
    logic        stat_clr;

    logic        pc_branch_sel;
    logic [15:0] pc_target;
    logic        flush_ifid;
    logic        busy;
    logic [15:0] taken_cnt;
    logic [15:0] not_taken_cnt;

    logic        s_sel;
    logic [15:0] s_target;
    logic        s_flush;
    logic        s_busy;
    logic [3:0]  s_taken;
    logic [3:0]  s_not_taken;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_flags(ex_flags), .ex_target(ex_target),
        .stat_clr(stat_clr),
        .pc_branch_sel(pc_branch_sel), .pc_target(pc_target),
        .flush_ifid(flush_ifid), .busy(busy),
        .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
    );

    branch_redirect_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_flags(ex_flags), .ex_target(ex_target),
        .stat_clr(stat_clr),
        .pc_branch_sel(s_sel), .pc_target(s_target),
        .flush_ifid(s_flush), .busy(s_busy),
        .taken_cnt(s_taken), .not_taken_cnt(s_not_taken)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ex_valid  = 1'b0;
        ex_opcode = 5'b0;
        ex_flags  = 2'b0;
        ex_target = 16'h0;
    endtask

    // Present one branch for one cycle; returns in the following cycle.
    task automatic br(input logic [4:0] op, input logic [1:0] fl,
                      input logic [15:0] tgt);
        ex_valid  = 1'b1;
        ex_opcode = op;
        ex_flags  = fl;
        ex_target = tgt;
        tick();
        idle_in();
    endtask

    initial begin
        rst_n    = 1'b0;
        stall    = 1'b0;
        stat_clr = 1'b0;
        idle_in();
        tick();
        tick();
        check("rst_sel", 32'(pc_branch_sel), 32'd0);
        check("rst_tgt", 32'(pc_target), 32'd0);
        check("rst_flush", 32'(flush_ifid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tk", 32'(taken_cnt), 32'd0);
        check("rst_nt", 32'(not_taken_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // basic taken BEQ
        br(BEQ, 2'b10, 16'h1234);
        check("beq_sel", 32'(pc_branch_sel), 32'd1);
        check("beq_tgt", 32'(pc_target), 32'h1234);
        check("beq_flush1", 32'(flush_ifid), 32'd1);
        check("beq_busy1", 32'(busy), 32'd1);
        check("beq_tk", 32'(taken_cnt), 32'd1);
        tick();
        check("beq_sel2", 32'(pc_branch_sel), 32'd0);
        check("beq_flush2", 32'(flush_ifid), 32'd1);
        tick();
        check("beq_flush3", 32'(flush_ifid), 32'd0);
        check("beq_busy3", 32'(busy), 32'd0);
        check("beq_tgt_hold", 32'(pc_target), 32'h1234);

        // condition sweep
        br(BNE, 2'b10, 16'h2000);
        check("bne_nt", 32'(not_taken_cnt), 32'd1);
        check("bne_flush", 32'(flush_ifid), 32'd0);
        check("bne_sel", 32'(pc_branch_sel), 32'd0);
        br(BLT, 2'b01, 16'h3000);
        check("blt_sel", 32'(pc_branch_sel), 32'd1);
        check("blt_tgt", 32'(pc_target), 32'h3000);
        check("blt_tk", 32'(taken_cnt), 32'd2);
        tick();
        tick();
        br(BGT, 2'b10, 16'h4000);
        check("bgt_nt", 32'(not_taken_cnt), 32'd2);
        check("bgt_nt_flush", 32'(flush_ifid), 32'd0);
        br(BGT, 2'b00, 16'h5000);
        check("bgt_sel", 32'(pc_branch_sel), 32'd1);
        check("bgt_tk", 32'(taken_cnt), 32'd3);
        tick();
        tick();
        br(5'b00001, 2'b10, 16'h6000);
        check("nob_sel", 32'(pc_branch_sel), 32'd0);
        check("nob_tk", 32'(taken_cnt), 32'd3);
        check("nob_nt", 32'(not_taken_cnt), 32'd2);
        check("nob_tgt", 32'(pc_target), 32'h5000);

        // wrong-path branches during FLUSH are ignored
        br(BLT, 2'b01, 16'h0BEE);
        check("wp_tk1", 32'(taken_cnt), 32'd4);
        ex_valid  = 1'b1;
        ex_opcode = BEQ;
        ex_flags  = 2'b10;
        ex_target = 16'h5555;
        tick();
        check("wp_sel", 32'(pc_branch_sel), 32'd0);
        check("wp_busy2", 32'(busy), 32'd1);
        tick();
        idle_in();
        check("wp_busy3", 32'(busy), 32'd0);
        check("wp_flush3", 32'(flush_ifid), 32'd0);
        check("wp_tk", 32'(taken_cnt), 32'd4);
        check("wp_tgt", 32'(pc_target), 32'h0BEE);

        // stall inside FLUSH
        br(BEQ, 2'b10, 16'h0ABC);
        stall = 1'b1;
        check("st_sel1", 32'(pc_branch_sel), 32'd1);
        check("st_tk", 32'(taken_cnt), 32'd5);
        tick();
        check("st_sel2", 32'(pc_branch_sel), 32'd1);
        tick();
        check("st_sel3", 32'(pc_branch_sel), 32'd1);
        tick();
        stall = 1'b0;
        check("st_sel4", 32'(pc_branch_sel), 32'd1);
        check("st_flush4", 32'(flush_ifid), 32'd1);
        tick();
        check("st_sel5", 32'(pc_branch_sel), 32'd0);
        check("st_flush5", 32'(flush_ifid), 32'd1);
        tick();
        check("st_flush6", 32'(flush_ifid), 32'd0);
        check("st_busy6", 32'(busy), 32'd0);

        // async reset mid-FLUSH
        br(BEQ, 2'b10, 16'h7777);
        rst_n = 1'b0;
        #1;
        check("ar_sel", 32'(pc_branch_sel), 32'd0);
        check("ar_tgt", 32'(pc_target), 32'd0);
        check("ar_flush", 32'(flush_ifid), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_tk", 32'(taken_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        br(BNE, 2'b00, 16'h0101);
        check("ar_idle_sel", 32'(pc_branch_sel), 32'd1);
        check("ar_idle_tk", 32'(taken_cnt), 32'd1);
        tick();
        tick();
        stat_clr = 1'b1;
        br(BEQ, 2'b10, 16'h0202);
        stat_clr = 1'b0;
        check("clr_tk", 32'(taken_cnt), 32'd0);
        check("clr_sel", 32'(pc_branch_sel), 32'd1);
        check("clr_tk4", 32'(s_taken), 32'd0);
        tick();
        tick();

        // saturation on the narrow instance
        for (int i = 0; i < 16; i++) begin
            br(BEQ, 2'b10, 16'(i));
            if (i == 14)
                check("sat_15", 32'(s_taken), 32'd15);
            tick();
            tick();
        end
        check("sat_hold", 32'(s_taken), 32'd15);
        check("sat_wide", 32'(taken_cnt), 32'd16);
        check("sat_nt", 32'(s_not_taken), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
